// File: rtl/alu_sequencer.sv
// Accumulator-based instruction sequencer: fetches the memory operand when needed,
// steers the external combinational ALU and writes its result back to the accumulator.
//
// state   | meaning
// IDLE    | ready for the next instruction
// RD_REQ  | one-cycle memory read request
// RD_WAIT | waiting for mem_rvalid, then capture the operand
// EXEC    | ALU result written to acc (ops 1-6), done pulse
// WR_REQ  | one-cycle store of acc, done pulse
module alu_sequencer #(
    parameter int WIDTH  = 12,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_rvalid,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [2:0]        alu_sel,
    input  logic [WIDTH-1:0]  alu_result,
    output logic [WIDTH-1:0]  acc,
    output logic              zero,
    output logic              done,
    output logic              illegal
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] WR_REQ  = 3'd4;

    localparam logic [2:0] SEL_PASS = 3'd1;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  opnd_q;
    logic [2:0]        op_sel;
    logic              acc_we;

    always_comb begin
        op_sel = SEL_PASS;
        case (op_q)
            4'd1: op_sel = 3'd0;
            4'd2: op_sel = 3'd1;
            4'd3: op_sel = 3'd2;
            4'd4: op_sel = 3'd3;
            4'd5: op_sel = 3'd4;
            4'd6: op_sel = 3'd5;
            default: op_sel = SEL_PASS;
        endcase
    end

    assign acc_we = (state == EXEC) && (op_q >= 4'd1) && (op_q <= 4'd6);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    if (instr_op >= 4'd2 && instr_op <= 4'd5)
                        state_nxt = RD_REQ;
                    else if (instr_op == 4'd7)
                        state_nxt = WR_REQ;
                    else
                        state_nxt = EXEC;
                end
            end
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: if (mem_rvalid) state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            WR_REQ:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state  <= IDLE;
            op_q   <= '0;
            addr_q <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && instr_valid) begin
                op_q   <= instr_op;
                addr_q <= instr_addr;
            end
            // Read data only counts while waiting for it; stray strobes elsewhere are dropped.
            if (state == RD_WAIT && mem_rvalid)
                opnd_q <= mem_rdata;
            if (acc_we)
                acc_q <= alu_result;
        end
    end

    assign instr_ready = (state == IDLE);
    assign mem_req     = (state == RD_REQ) || (state == WR_REQ);
    assign mem_we      = (state == WR_REQ);
    assign mem_addr    = addr_q;
    assign mem_wdata   = acc_q;
    assign alu_a       = acc_q;
    assign alu_b       = opnd_q;
    assign alu_sel     = (state == EXEC) ? op_sel : SEL_PASS;
    assign acc         = acc_q;
    assign zero        = (acc_q == '0);
    assign done        = (state == EXEC) || (state == WR_REQ);
    assign illegal     = (state == EXEC) && op_q[3];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and hand-driven memory responses.
module tb_alu_sequencer;

    localparam int WIDTH  = 12;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [3:0]        instr_op = '0;
    logic [ADDR_W-1:0] instr_addr = '0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_rvalid = 1'b0;
    logic [WIDTH-1:0]  mem_rdata = '0;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [2:0]        alu_sel;
    logic [WIDTH-1:0]  alu_result;
    logic [WIDTH-1:0]  acc;
    logic              zero;
    logic              done;
    logic              illegal;

    int total = 0;
    int bad   = 0;

    alu_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstN(rstN),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_addr(instr_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .acc(acc), .zero(zero), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference ALU the sequencer drives
    logic [2*WIDTH-1:0] prod;
    assign prod = alu_a * alu_b;
    always_comb begin
        alu_result = '0;
        case (alu_sel)
            3'd0: alu_result = '0;
            3'd1: alu_result = alu_b;
            3'd2: alu_result = alu_a + alu_b;
            3'd3: alu_result = alu_a - alu_b;
            3'd4: alu_result = prod[WIDTH-1:0];
            3'd5: alu_result = alu_a + 12'd1;
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an instruction in cycle 0 and returns positioned in cycle 1.
    task automatic issue(input logic [3:0] op, input logic [ADDR_W-1:0] addr);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_addr  = addr;
        chk("ready_at_issue", {31'd0, instr_ready}, 32'd1);
        step();
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_addr  = '0;
    endtask

    // Memory-operand op: extra = cycles between RD_WAIT entry and rvalid.
    task automatic mem_op(input string tag, input logic [3:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [WIDTH-1:0] data, input int extra,
                          input logic [WIDTH-1:0] exp_acc);
        issue(op, addr);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_addr"}, {24'd0, mem_addr}, {24'd0, addr});
        step();
        chk({tag, "_req_one_cycle"}, {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < extra; i++) step();
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 12'hABC;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        step();
        chk({tag, "_acc"}, {20'd0, acc}, {20'd0, exp_acc});
        chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    endtask

    initial begin
        #2;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_acc", {20'd0, acc}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_sel", {29'd0, alu_sel}, 32'd1);
        chk("rst_outs", {28'd0, mem_req, mem_we, done, illegal}, 32'd0);
        chk("rst_addr", {24'd0, mem_addr}, 32'd0);
        step();
        rstN = 1'b1;
        step();

        // INC x3 back to back, done in cycles 1,3,5
        for (int k = 1; k <= 3; k++) begin
            issue(4'd6, 8'h00);
            chk("inc_done", {31'd0, done}, 32'd1);
            chk("inc_sel", {29'd0, alu_sel}, 32'd5);
            chk("inc_busy", {31'd0, instr_ready}, 32'd0);
            chk("inc_zero_before", {31'd0, zero}, (k == 1) ? 32'd1 : 32'd0);
            step();
            chk("inc_acc", {20'd0, acc}, k);
            chk("inc_done_clear", {31'd0, done}, 32'd0);
        end

        // LOAD 0x10, memory answers 3 cycles after mem_req
        mem_op("load", 4'd2, 8'h10, 12'd100, 2, 12'd100);

        // Stray rvalid in IDLE must not touch the operand register
        mem_rvalid = 1'b1;
        mem_rdata  = 12'd999;
        step();
        mem_rvalid = 1'b0;
        chk("stray_rvalid_b", {20'd0, alu_b}, 32'd100);
        chk("stray_rvalid_idle", {31'd0, instr_ready}, 32'd1);

        // Arithmetic with wrap
        mem_op("load5", 4'd2, 8'h01, 12'd5, 0, 12'd5);
        mem_op("sub", 4'd4, 8'h02, 12'd7, 1, 12'hFFE);
        mem_op("mul", 4'd5, 8'h03, 12'hFFD, 0, 12'd6);
        mem_op("load1", 4'd2, 8'h04, 12'd1, 0, 12'd1);
        mem_op("add_wrap", 4'd3, 8'h05, 12'd2047, 3, 12'h800);

        // CLR
        issue(4'd1, 8'h00);
        chk("clr_sel", {29'd0, alu_sel}, 32'd0);
        step();
        chk("clr_acc", {20'd0, acc}, 32'd0);
        chk("clr_zero", {31'd0, zero}, 32'd1);

        // STORE acc=42 to 0x3F
        mem_op("load42", 4'd2, 8'h06, 12'd42, 0, 12'd42);
        issue(4'd7, 8'h3F);
        chk("st_req_we_done", {29'd0, mem_req, mem_we, done}, 32'd7);
        chk("st_addr", {24'd0, mem_addr}, 32'h3F);
        chk("st_wdata", {20'd0, mem_wdata}, 32'd42);
        chk("st_sel", {29'd0, alu_sel}, 32'd1);
        step();
        chk("st_after", {29'd0, mem_req, done, instr_ready}, 32'd1);
        chk("st_acc", {20'd0, acc}, 32'd42);

        // NOP: done, no illegal, acc unchanged
        issue(4'd0, 8'h00);
        chk("nop_done_ill", {30'd0, done, illegal}, 32'd2);
        step();
        chk("nop_acc", {20'd0, acc}, 32'd42);

        // Illegal opcode 12
        issue(4'd12, 8'h55);
        chk("ill_done_ill", {30'd0, done, illegal}, 32'd3);
        chk("ill_no_req", {31'd0, mem_req}, 32'd0);
        step();
        chk("ill_clear", {30'd0, done, illegal}, 32'd0);
        chk("ill_acc", {20'd0, acc}, 32'd42);
        chk("ill_ready", {31'd0, instr_ready}, 32'd1);

        // Reset during RD_WAIT, late rvalid after release
        issue(4'd2, 8'h20);
        step();
        chk("rw_busy", {31'd0, instr_ready}, 32'd0);
        rstN = 1'b0;
        #1;
        chk("rw_rst_acc", {20'd0, acc}, 32'd0);
        chk("rw_rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rw_rst_addr", {24'd0, mem_addr}, 32'd0);
        step();
        rstN = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 12'd77;
        step();
        mem_rvalid = 1'b0;
        chk("rw_no_done", {31'd0, done}, 32'd0);
        chk("rw_ready", {31'd0, instr_ready}, 32'd1);
        chk("rw_b", {20'd0, alu_b}, 32'd0);
        step();
        chk("rw_acc", {20'd0, acc}, 32'd0);
        chk("rw_no_done2", {31'd0, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction-level controller that drives the combinational ALU of a processing core from the other side of its interface. It owns the accumulator, accepts one instruction at a time over a valid/ready handshake, and fetches the memory operand when the instruction needs one. It then presents accumulator, operand and `selectOp` code to the ALU and writes the ALU result back into the accumulator. It sits between the core's instruction issue logic and the ALU/data-memory pair.

## Interface
- `WIDTH`, 12, data width of accumulator, ALU operands and memory data
- `ADDR_W`, 8, data-memory address width
- `clk`  in  1  core clock, all state updates on rising edge
- `rstN`  in  1  asynchronous active-low reset
- `instr_valid`  in  1  instruction present
- `instr_ready`  out  1  sequencer can accept an instruction (IDLE only)
- `instr_op`  in  4  opcode
- `instr_addr`  in  ADDR_W  memory operand/store address (ignored for non-memory ops)
- `mem_req`  out  1  one-cycle memory request strobe
- `mem_we`  out  1  1 = write, 0 = read; qualified by `mem_req`
- `mem_addr`  out  ADDR_W  latched `instr_addr`
- `mem_wdata`  out  WIDTH  accumulator value for stores
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  WIDTH  read data
- `alu_a`  out  WIDTH  accumulator, always driven
- `alu_b`  out  WIDTH  operand register
- `alu_sel`  out  3  ALU op: 0 clr, 1 pass, 2 add, 3 sub, 4 mul, 5 inc
- `alu_result`  in  WIDTH  ALU output, signed, already truncated to WIDTH
- `acc`  out  WIDTH  accumulator value
- `zero`  out  1  combinational `acc == 0`
- `done`  out  1  one-cycle pulse when an instruction retires
- `illegal`  out  1  one-cycle pulse, coincident with `done`, for an undefined opcode

## Operation
- Opcodes:
  - 0 NOP
  - 1 CLR (alu_sel 0)
  - 2 LOAD mem (pass, 1)
  - 3 ADD mem (2)
  - 4 SUB mem (3, acc − mem)
  - 5 MUL mem (4, low WIDTH bits)
  - 6 INC (5)
  - 7 STORE acc→mem
  - 8–15 illegal, behave as NOP and pulse `illegal`
- States: IDLE, RD_REQ, RD_WAIT, EXEC, WR_REQ.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`, latch op and addr, then go to:
    - RD_REQ for ops 2–5
    - WR_REQ for op 7
    - EXEC otherwise
- RD_REQ: `mem_req`=1, `mem_we`=0 for exactly one cycle → RD_WAIT.
- RD_WAIT: wait indefinitely. On the first cycle with `mem_rvalid`=1, operand register ← `mem_rdata` → EXEC.
- EXEC:
  - `alu_sel` = op's code.
  - For ops 1–6, acc ← `alu_result` at the end of the cycle.
  - `done`=1 → IDLE.
- WR_REQ: `mem_req`=1, `mem_we`=1, `mem_wdata`=acc, `done`=1 → IDLE. Fire-and-forget; no write acknowledge.
- Outside EXEC, `alu_sel`=1 (pass) and acc is not written.
- `mem_rvalid` is ignored in every state except RD_WAIT.
- Arithmetic is two's complement, WIDTH bits; overflow wraps silently.

## Timing
- Reset (async, any state): state IDLE, acc 0, operand reg 0, `instr_ready`=1, `mem_req`/`mem_we`/`done`/`illegal`=0, `alu_sel`=1, `mem_addr`=0, `zero`=1.
- Instruction accepted in cycle 0 (`instr_valid` & `instr_ready`).
- CLR/INC/NOP/illegal: EXEC in cycle 1 with `done`. New acc visible cycle 2. `instr_ready` again in cycle 2.
- Memory ops with `mem_rvalid` first in cycle 2: `mem_req` in cycle 1, operand captured at the end of cycle 2, EXEC/`done` in cycle 3, acc visible cycle 4. Each extra wait cycle adds one cycle.
- STORE: `mem_req`/`mem_we`/`done` in cycle 1, back in IDLE cycle 2.
- Throughput: at most one instruction in flight. `instr_ready`=0 from cycle 1 until back in IDLE.
- Reset asserted mid-RD_WAIT: the late `mem_rvalid` arriving after reset release is ignored.

## Test plan
- Reset then INC ×3 → acc 1, 2, 3; `done` pulses in cycles 1, 3, 5; `zero` 1→0 after the first INC.
- LOAD addr 0x10 (mem = 12'sd100), memory returns 3 cycles after `mem_req` → `mem_req` exactly 1 cycle, `mem_addr`=0x10, acc=100 the cycle after EXEC.
- acc=5, SUB mem=7 → acc=−2 (12'hFFE). Then MUL mem=−3 → acc=6. Then ADD mem=2047 with acc=1 → acc=−2048 (wrap).
- acc=42, STORE addr 0x3F → single cycle with `mem_req`=1, `mem_we`=1, `mem_addr`=0x3F, `mem_wdata`=42, `done`=1; acc unchanged.
- Opcode 12 → `done` and `illegal` both pulse in cycle 1, acc unchanged, no `mem_req`.
- LOAD issued, `rstN` low during RD_WAIT, `mem_rvalid` high right after release → acc stays 0, state IDLE, `instr_ready`=1, no `done`.
